// File: rtl/mult_defs_pkg.sv
// Shared definitions for the sequential 32x32 multiplier: operand width,
// iteration counter width and FSM state encoding.
package mult_defs_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        CORR_A,
        CORR_B,
        DONE
    } state_e;

endpackage

// File: rtl/seq_multiplier_32_adder.sv
// The existing 32-bit ripple adder that the multiplier shares for every
// partial product and sign-correction step.
module _32bit_adder (
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        carry_in,
    output logic [31:0] S,
    output logic        carry_out
);

    assign {carry_out, S} = {1'b0, A} + {1'b0, B} + {32'b0, carry_in};

endmodule

// File: rtl/seq_multiplier_32.sv
// Multi-cycle 32x32->64 shift-add multiplier, one partial product per clock.
// Define MULT_SIGNED_EN for two's-complement operands (adds CORR_A/CORR_B).
module seq_multiplier_32
    import mult_defs_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    state_e           state_q;
    logic [WIDTH-1:0] aReg_q;
`ifdef MULT_SIGNED_EN
    logic [WIDTH-1:0] bReg_q;
`endif
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] addB;
    logic             addCin;
    logic [WIDTH-1:0] sum;
    logic             carryOut;
    logic [WIDTH-1:0] hi_d;
    logic [WIDTH-1:0] lo_d;

    // Operand select for the single shared adder; A is always the high half.
    always_comb begin
        addB   = '0;
        addCin = 1'b0;
        case (state_q)
            CALC: addB = lo_q[0] ? aReg_q : '0;
`ifdef MULT_SIGNED_EN
            CORR_A: if (aReg_q[WIDTH-1]) begin
                addB   = ~bReg_q;
                addCin = 1'b1;
            end
            CORR_B: if (bReg_q[WIDTH-1]) begin
                addB   = ~aReg_q;
                addCin = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    _32bit_adder uAdder (
        .A         (hi_q),
        .B         (addB),
        .carry_in  (addCin),
        .S         (sum),
        .carry_out (carryOut)
    );

    assign hi_d = {carryOut, sum[WIDTH-1:1]};
    assign lo_d = {sum[0], lo_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            aReg_q  <= '0;
`ifdef MULT_SIGNED_EN
            bReg_q  <= '0;
`endif
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    aReg_q  <= a;
`ifdef MULT_SIGNED_EN
                    bReg_q  <= b;
`endif
                    hi_q    <= '0;
                    lo_q    <= b;
                    cnt_q   <= '0;
                    state_q <= CALC;
                end
                CALC: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef MULT_SIGNED_EN
                        state_q <= CORR_A;
`else
                        state_q <= DONE;
`endif
                    end
                end
`ifdef MULT_SIGNED_EN
                // Correction terms only touch the high half; carry out is dropped.
                CORR_A: begin
                    hi_q    <= sum;
                    state_q <= CORR_B;
                end
                CORR_B: begin
                    hi_q    <= sum;
                    state_q <= DONE;
                end
`endif
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy    = (state_q != IDLE) && (state_q != DONE);
    assign done    = (state_q == DONE);
    assign product = {hi_q, lo_q};

endmodule
